// File: rtl/sim_run_controller_pkg.sv
// Shared definitions for the simulation run controller: state encodings and flag indices.
package sim_run_controller_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned NUM_FLAGS = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_STALL   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    localparam int unsigned FLAG_DONE    = 0;
    localparam int unsigned FLAG_STALL   = 1;
    localparam int unsigned FLAG_TIMEOUT = 2;

    // The core is out of reset only while the program runs or drains.
    function automatic logic is_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sim_idle_counter.sv
// Per-channel idle counter: counts RUN cycles since the last heartbeat, flags the limit cycle.
module sim_idle_counter #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic beat,
    input  logic run,
    output logic hit_c
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] idle_q;

    assign hit_c = run && en && !beat && (idle_q == LAST);

    // Disabled channels are pinned at zero so they can never stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (!en) begin
            idle_q <= '0;
        end else if (run) begin
            if (beat) begin
                idle_q <= '0;
            end else if (idle_q != CNT_MAX) begin
                idle_q <= idle_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller for the simulation top: core reset sequencing, cycle counting, stall
// detection on heartbeat channels and terminal DONE/STALL/TIMEOUT reporting.
module sim_run_controller
    import sim_run_controller_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 25,
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned IDLE_LIMIT      = 1_000_000,
    parameter int unsigned DRAIN_CYCLES    = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 15_000_000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_CH-1:0]  heartbeat_in,
    input  logic [NUM_CH-1:0]  ch_en_in,
    input  logic               halt_req_in,
    output logic               sim_rst_out,
    output logic [STATE_W-1:0] state_out,
    output logic [CNT_W-1:0]   cycle_cnt_out,
    output logic [NUM_CH-1:0]  stall_ch_out,
    output logic               done_out,
    output logic               stall_out,
    output logic               timeout_out
);

    typedef logic [CNT_W-1:0] cnt_t;

    // A zero-length phase still takes one edge to leave its state.
    localparam int unsigned HOLD_LAST    = (RST_HOLD_CYCLES > 0) ? RST_HOLD_CYCLES - 1 : 0;
    localparam int unsigned DRAIN_LAST   = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam cnt_t        CNT_MAX      = '1;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

    state_e                state_q;
    state_e                state_d;
    cnt_t                  hold_q;
    cnt_t                  drain_q;
    cnt_t                  cycle_q;
    logic [NUM_FLAGS-1:0]  flag_q;
    logic [NUM_CH-1:0]     hit_c;
    logic                  run_c;

    assign run_c = (state_q == ST_RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : gen_idle
        sim_idle_counter #(
            .CNT_W (CNT_W),
            .LIMIT (IDLE_LIMIT)
        ) u_idle (
            .clk   (clk_in),
            .rst_n (rst_n_in),
            .en    (ch_en_in[i]),
            .beat  (heartbeat_in[i]),
            .run   (run_c),
            .hit_c (hit_c[i])
        );
    end

    // Next state; in RUN a halt request outranks a stall, which outranks the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HOLD: begin
                if (hold_q >= cnt_t'(HOLD_LAST)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req_in)                          state_d = ST_DRAIN;
                else if (|hit_c)                          state_d = ST_STALL;
                else if (cycle_q == cnt_t'(TIMEOUT_LAST)) state_d = ST_TIMEOUT;
            end
            ST_DRAIN: begin
                if (drain_q >= cnt_t'(DRAIN_LAST))        state_d = ST_DONE;
                else if (cycle_q == cnt_t'(TIMEOUT_LAST)) state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_HOLD;
            hold_q       <= '0;
            drain_q      <= '0;
            cycle_q      <= '0;
            stall_ch_out <= '0;
            flag_q       <= '0;
            sim_rst_out  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == ST_HOLD)  hold_q  <= sat_inc(hold_q);
            if (is_busy(state_q))    cycle_q <= sat_inc(cycle_q);
            if (state_q == ST_DRAIN) drain_q <= sat_inc(drain_q);
            if (run_c && (state_d == ST_STALL)) stall_ch_out <= hit_c;
            flag_q[FLAG_DONE]    <= (state_d == ST_DONE);
            flag_q[FLAG_STALL]   <= (state_d == ST_STALL);
            flag_q[FLAG_TIMEOUT] <= (state_d == ST_TIMEOUT);
            sim_rst_out          <= !is_busy(state_d);
        end
    end

    assign state_out     = state_q;
    assign cycle_cnt_out = cycle_q;
    assign done_out      = flag_q[FLAG_DONE];
    assign stall_out     = flag_q[FLAG_STALL];
    assign timeout_out   = flag_q[FLAG_TIMEOUT];

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed scenarios with literal expectations plus random runs,
// all outputs compared every cycle against a cycle-count model of the run rules.
module tb_sim_run_controller;

    localparam int R_HOLD = 25;
    localparam int NCH    = 4;
    localparam int LIM    = 8;
    localparam int DRN    = 64;
    localparam int TOUT   = 300;
    localparam int CW     = 16;
    localparam int CMAX   = (1 << CW) - 1;

    logic            clk_in       = 1'b0;
    logic            rst_n_in     = 1'b1;
    logic [NCH-1:0]  heartbeat_in = '0;
    logic [NCH-1:0]  ch_en_in     = '0;
    logic            halt_req_in  = 1'b0;
    logic            sim_rst_out;
    logic [2:0]      state_out;
    logic [CW-1:0]   cycle_cnt_out;
    logic [NCH-1:0]  stall_ch_out;
    logic            done_out;
    logic            stall_out;
    logic            timeout_out;

    sim_run_controller #(
        .RST_HOLD_CYCLES (R_HOLD),
        .NUM_CH          (NCH),
        .IDLE_LIMIT      (LIM),
        .DRAIN_CYCLES    (DRN),
        .TIMEOUT_CYCLES  (TOUT),
        .CNT_W           (CW)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .heartbeat_in  (heartbeat_in),
        .ch_en_in      (ch_en_in),
        .halt_req_in   (halt_req_in),
        .sim_rst_out   (sim_rst_out),
        .state_out     (state_out),
        .cycle_cnt_out (cycle_cnt_out),
        .stall_ch_out  (stall_ch_out),
        .done_out      (done_out),
        .stall_out     (stall_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase code plus plain cycle tallies (edges held, cycles busy, cycles draining,
    // cycles since each channel's last beat).
    int             m_state = 0;
    int             m_hold  = 0;
    int             m_busy  = 0;
    int             m_drain = 0;
    int             m_since [NCH] = '{default: 0};
    logic [NCH-1:0] m_mask  = '0;

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_busy = 0; m_drain = 0; m_mask = '0;
        for (int c = 0; c < NCH; c++) m_since[c] = 0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] hits;
        int             busy_before;
        hits        = '0;
        busy_before = m_busy;
        if (m_state == 0) begin
            m_hold++;
            if (m_hold >= ((R_HOLD > 0) ? R_HOLD : 1)) m_state = 1;
        end else if (m_state == 1) begin
            for (int c = 0; c < NCH; c++)
                if (ch_en_in[c] && !heartbeat_in[c] && m_since[c] == LIM - 1) hits[c] = 1'b1;
            m_busy = (m_busy < CMAX) ? m_busy + 1 : CMAX;
            for (int c = 0; c < NCH; c++)
                m_since[c] = (!ch_en_in[c] || heartbeat_in[c]) ? 0 : m_since[c] + 1;
            if (halt_req_in) m_state = 2;
            else if (hits != 0) begin m_state = 4; m_mask = hits; end
            else if (busy_before == TOUT - 1) m_state = 5;
        end else if (m_state == 2) begin
            m_busy = (m_busy < CMAX) ? m_busy + 1 : CMAX;
            m_drain++;
            for (int c = 0; c < NCH; c++) if (!ch_en_in[c]) m_since[c] = 0;
            if (m_drain >= DRN) m_state = 3;
            else if (busy_before == TOUT - 1) m_state = 5;
        end
    endtask

    initial forever begin
        @(posedge clk_in or negedge rst_n_in);
        if (!rst_n_in) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            check("cmp_state",   state_out, m_state);
            check("cmp_sim_rst", sim_rst_out, (m_state == 1 || m_state == 2) ? 0 : 1);
            check("cmp_cycles",  cycle_cnt_out, m_busy);
            check("cmp_stall_ch", stall_ch_out, m_mask);
            check("cmp_done",    done_out, (m_state == 3) ? 1 : 0);
            check("cmp_stall",   stall_out, (m_state == 4) ? 1 : 0);
            check("cmp_timeout", timeout_out, (m_state == 5) ? 1 : 0);
        end
    end

    // One run: short async reset pulse between edges, hold, then RUN cycles k=1.. driven
    // either from fixed beat periods/halt cycle or randomly. stop_at>0 abandons the run mid-RUN.
    task automatic scenario(input logic [NCH-1:0] en, input int p0, input int p1, input int p2,
                            input int p3, input int halt_at, input bit rnd, input int stop_at,
                            output int hold_edges);
        int             per [NCH];
        logic [NCH-1:0] cur_en;
        logic [NCH-1:0] b;
        logic           h;
        int             idx;
        per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        ch_en_in = '0; heartbeat_in = '0; halt_req_in = 1'b0;
        #1;
        check("rst_state",    state_out, 0);
        check("rst_sim_rst",  sim_rst_out, 1);
        check("rst_cycles",   cycle_cnt_out, 0);
        check("rst_flags",    {done_out, stall_out, timeout_out}, 0);
        check("rst_stall_ch", stall_ch_out, 0);
        rst_n_in = 1'b1;
        chk_en   = 1'b1;
        hold_edges = 0;
        while (sim_rst_out === 1'b1 && hold_edges < 60) begin
            @(posedge clk_in);
            #1;
            hold_edges++;
        end
        cur_en = en;
        for (int k = 1; k <= 400; k++) begin
            if (k == stop_at) return;
            if (rnd) begin
                if ($urandom_range(0, 19) == 0) begin
                    idx = int'($urandom_range(0, NCH - 1));
                    cur_en[idx] = ~cur_en[idx];
                end
                for (int c = 0; c < NCH; c++) b[c] = ($urandom_range(0, 4) == 0);
                h = ($urandom_range(0, 199) == 0);
            end else begin
                for (int c = 0; c < NCH; c++) b[c] = (per[c] != 0) && (k % per[c] == 0);
                h = (k == halt_at);
            end
            ch_en_in = cur_en; heartbeat_in = b; halt_req_in = h;
            @(posedge clk_in);
            #1;
            if (m_state >= 3) break;
        end
        check("run_reaches_end", (state_out >= 3) ? 1 : 0, 1);
        // Terminal states must ignore further halts, beats and enable changes.
        repeat (4) begin
            ch_en_in     = NCH'($urandom_range(0, 15));
            heartbeat_in = NCH'($urandom_range(0, 15));
            halt_req_in  = 1'b1;
            @(posedge clk_in);
            #1;
        end
        halt_req_in = 1'b0;
    endtask

    initial begin
        int he;
        // 1+2: hold length, then ch1 silent stalls on the 8th RUN cycle
        scenario(4'b0011, 4, 0, 0, 0, 0, 1'b0, 0, he);
        check("t1_hold_edges", he, 25);
        check("t2_state",    state_out, 4);
        check("t2_stall_ch", stall_ch_out, 4'b0010);
        check("t2_stall",    stall_out, 1);
        check("t2_sim_rst",  sim_rst_out, 1);
        check("t2_cycles",   cycle_cnt_out, 8);
        check("t2_others",   {done_out, timeout_out}, 0);
        // 3: halt on RUN cycle 100, drain 64 -> DONE with 164 cycles
        scenario(4'b1111, 1, 1, 1, 1, 100, 1'b0, 0, he);
        check("t3_state",  state_out, 3);
        check("t3_done",   done_out, 1);
        check("t3_cycles", cycle_cnt_out, 164);
        // 4a: no halt, all beating -> TIMEOUT at cycle 300
        scenario(4'b1111, 1, 1, 1, 1, 0, 1'b0, 0, he);
        check("t4a_state",   state_out, 5);
        check("t4a_timeout", timeout_out, 1);
        check("t4a_cycles",  cycle_cnt_out, 300);
        // 4b: halt on cycle 299 wins, then timeout during drain
        scenario(4'b1111, 1, 1, 1, 1, 299, 1'b0, 0, he);
        check("t4b_state",  state_out, 5);
        check("t4b_cycles", cycle_cnt_out, 300);
        check("t4b_done",   done_out, 0);
        // 5: halt on the same cycle ch2 hits its limit -> drain, no stall recorded
        scenario(4'b0100, 0, 0, 0, 0, 8, 1'b0, 0, he);
        check("t5_state",    state_out, 3);
        check("t5_stall_ch", stall_ch_out, 0);
        check("t5_cycles",   cycle_cnt_out, 72);
        // 6: abandon test 3 mid-RUN, the next run's reset pulse lands mid-RUN
        scenario(4'b1111, 1, 1, 1, 1, 100, 1'b0, 50, he);
        check("t6_mid_state",  state_out, 1);
        check("t6_mid_cycles", cycle_cnt_out, 49);
        scenario(4'b1111, 1, 1, 1, 1, 100, 1'b0, 0, he);
        check("t6_hold_edges", he, 25);
        check("t6_cycles",     cycle_cnt_out, 164);
        check("t6_done",       done_out, 1);
        // random runs against the model
        for (int r = 0; r < 25; r++) begin
            scenario(NCH'($urandom_range(1, 15)), 0, 0, 0, 0, 0, 1'b1, 0, he);
            check("rnd_hold_edges", he, 25);
        end
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
